// File: rtl/cdc_handshake_tx.sv
// rtl/cdc_handshake_tx.sv - source side of a 4-phase req/ack clock-domain crossing
// Optional macro CDC_TX_TIMEOUT_EN bounds the REQ_HIGH/REQ_LOW waits and pulses error on abort.
module cdc_handshake_tx #(
  parameter int DATA_WIDTH     = 8,
  parameter int SYNC_BITS      = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  send_valid,
  input  logic [DATA_WIDTH-1:0] send_data,
  output logic                  send_ready,
  output logic                  req,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic                  ack,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    REQ_HIGH,
    REQ_LOW
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [SYNC_BITS-1:0]  ack_sync;
  logic                  ack_s;
  logic                  req_next;
  logic                  done_next;
  logic                  error_next;
  logic [DATA_WIDTH-1:0] data_next;
  logic                  timeout;

  if (SYNC_BITS < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("cdc_handshake_tx: SYNC_BITS must be >= 2 and TIMEOUT_CYCLES >= 1");
  end

  // Chain resets to ones so a fresh block looks busy until a real ack=0 arrives.
  always_ff @(posedge clock) begin
    if (reset) begin
      ack_sync <= '1;
    end else begin
      ack_sync <= {ack_sync[SYNC_BITS-2:0], ack};
    end
  end

  assign ack_s      = ack_sync[SYNC_BITS-1];
  assign send_ready = (state == IDLE) && !ack_s;

`ifdef CDC_TX_TIMEOUT_EN
  localparam int            CW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] wait_cnt;

  always_ff @(posedge clock) begin
    if (reset || (state_next != state)) begin
      wait_cnt <= '0;
    end else if (state == REQ_HIGH || state == REQ_LOW) begin
      wait_cnt <= wait_cnt + CW'(1);
    end
  end

  assign timeout = (state == REQ_HIGH || state == REQ_LOW) && (wait_cnt == LAST);
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      req      <= 1'b0;
      data_out <= '0;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      state    <= state_next;
      req      <= req_next;
      data_out <= data_next;
      done     <= done_next;
      error    <= error_next;
    end
  end

  always_comb begin
    state_next = state;
    req_next   = req;
    data_next  = data_out;
    done_next  = 1'b0;
    error_next = 1'b0;
    case (state)
      IDLE: begin
        if (send_valid && send_ready) begin
          data_next  = send_data;
          state_next = SETUP;
        end
      end
      // One settle cycle so data_out is stable before req rises.
      SETUP: begin
        req_next   = 1'b1;
        state_next = REQ_HIGH;
      end
      REQ_HIGH: begin
        if (ack_s) begin
          req_next   = 1'b0;
          state_next = REQ_LOW;
        end else if (timeout) begin
          req_next   = 1'b0;
          error_next = 1'b1;
          state_next = IDLE;
        end
      end
      REQ_LOW: begin
        if (!ack_s) begin
          done_next  = 1'b1;
          state_next = IDLE;
        end else if (timeout) begin
          error_next = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        req_next   = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// tb/tb_cdc_handshake_tx.sv - directed scoreboard bench for cdc_handshake_tx
module tb_cdc_handshake_tx;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       send_valid = 1'b0;
  logic [7:0] send_data = 8'h00;
  logic       send_ready;
  logic       req;
  logic [7:0] data_out;
  logic       ack = 1'b0;
  logic       done;
  logic       error;

  int         n_total = 0;
  int         n_pass = 0;
  int         done_cnt = 0;
  int         base_cnt;
  int         k;
  logic       done_now = 1'b0;
  logic       err_seen = 1'b0;
  logic       rx_mode = 1'b0;
  logic       rx_d0 = 1'b0;
  logic       rx_d1 = 1'b0;
  logic [7:0] sb[$];

  cdc_handshake_tx #(
    .DATA_WIDTH    (8),
    .SYNC_BITS     (3),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .send_valid(send_valid),
    .send_data (send_data),
    .send_ready(send_ready),
    .req       (req),
    .data_out  (data_out),
    .ack       (ack),
    .done      (done),
    .error     (error)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One clock: sample outputs 1ns after the edge, score done pulses, then run the receiver.
  task automatic tick();
    @(posedge clock);
    #1;
    done_now = done;
    if (error === 1'b1) err_seen = 1'b1;
    if (done === 1'b1) begin
      done_cnt++;
      chk("done_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) chk("done_data", 32'(data_out), 32'(sb.pop_front()));
      chk("done_no_error", 32'(error), 32'd0);
    end
    if (rx_mode) begin
      ack   = rx_d1;
      rx_d1 = rx_d0;
      rx_d0 = req;
    end
  endtask

  task automatic wait_ack(input logic val, input string tag);
    int n = 0;
    while (ack !== val && n < 50) begin
      tick();
      n++;
    end
    chk(tag, 32'(ack), 32'(val));
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!done_now && n < 100);
    chk(tag, 32'(done_now), 32'd1);
  endtask

  initial begin
    // Reset state and startup gating
    tick();
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_data", 32'(data_out), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_ready", 32'(send_ready), 32'd0);
    reset = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("t1_ready", 32'(send_ready), (i == 3) ? 32'd1 : 32'd0);
      chk("t1_req", 32'(req), 32'd0);
      chk("t1_data", 32'(data_out), 32'd0);
    end

    // Single transfer with echoing receiver
    rx_mode = 1'b1;
    rx_d0 = 1'b0;
    rx_d1 = 1'b0;
    send_data = 8'hA5;
    send_valid = 1'b1;
    sb.push_back(8'hA5);
    tick();
    chk("t2_data_at_accept", 32'(data_out), 32'h A5);
    chk("t2_req_setup", 32'(req), 32'd0);
    send_valid = 1'b0;
    tick();
    chk("t2_req_rise", 32'(req), 32'd1);
    wait_ack(1'b1, "t2_ack_rise");
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("t2_req_fall", 32'(req), (i == 4) ? 32'd0 : 32'd1);
    end
    wait_ack(1'b0, "t2_ack_fall");
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("t2_done", 32'(done), (i == 4) ? 32'd1 : 32'd0);
    end
    chk("t2_ready_with_done", 32'(send_ready), 32'd1);

    // Back-to-back with send_data disturbance
    base_cnt = done_cnt;
    send_data = 8'h01;
    send_valid = 1'b1;
    sb.push_back(8'h01);
    tick();
    chk("t3_accept1", 32'(data_out), 32'h01);
    send_data = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t3_hold_ff", 32'(data_out), 32'h01);
    end
    send_data = 8'h02;
    sb.push_back(8'h02);
    k = 0;
    do begin
      tick();
      k++;
      if (!done_now) chk("t3_hold", 32'(data_out), 32'h01);
    end while (!done_now && k < 100);
    chk("t3_done1_seen", 32'(done_now), 32'd1);
    tick();
    chk("t3_accept2", 32'(data_out), 32'h02);
    chk("t3_busy2", 32'(send_ready), 32'd0);
    send_valid = 1'b0;
    wait_done("t3_done2_seen");
    chk("t3_done_count", 32'(done_cnt - base_cnt), 32'd2);

    // Stuck ack in IDLE
    rx_mode = 1'b0;
    ack = 1'b1;
    repeat (3) tick();
    send_data = 8'h3C;
    send_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("t4_ready_low", 32'(send_ready), 32'd0);
      chk("t4_req_low", 32'(req), 32'd0);
    end
    chk("t4_no_accept", 32'(data_out), 32'h02);
    ack = 1'b0;
    sb.push_back(8'h3C);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("t4_ready_rise", 32'(send_ready), (i == 3) ? 32'd1 : 32'd0);
    end
    tick();
    chk("t4_accept", 32'(data_out), 32'h3C);
    send_valid = 1'b0;
    rx_d0 = 1'b0;
    rx_d1 = 1'b0;
    rx_mode = 1'b1;
    wait_done("t4_done_seen");

    // Reset in REQ_HIGH abandons the transfer silently
    send_data = 8'h5A;
    send_valid = 1'b1;
    tick();
    send_valid = 1'b0;
    tick();
    chk("t5_req_high", 32'(req), 32'd1);
    rx_mode = 1'b0;
    ack = 1'b0;
    rx_d0 = 1'b0;
    rx_d1 = 1'b0;
    reset = 1'b1;
    tick();
    chk("t5_req_reset", 32'(req), 32'd0);
    chk("t5_done_reset", 32'(done), 32'd0);
    chk("t5_error_reset", 32'(error), 32'd0);
    chk("t5_data_reset", 32'(data_out), 32'd0);
    reset = 1'b0;
    k = 0;
    while (send_ready !== 1'b1 && k < 10) begin
      tick();
      k++;
    end
    chk("t5_ready_after_reset", 32'(send_ready), 32'd1);
    rx_mode = 1'b1;
    send_data = 8'h96;
    send_valid = 1'b1;
    sb.push_back(8'h96);
    tick();
    chk("t5_accept", 32'(data_out), 32'h96);
    send_valid = 1'b0;
    wait_done("t5_done_seen");
    chk("t5_no_error_so_far", 32'(err_seen), 32'd0);
    chk("t5_sb_drained", 32'(sb.size()), 32'd0);

    // Receiver never answers
    rx_mode = 1'b0;
    ack = 1'b0;
    base_cnt = done_cnt;
    send_data = 8'hC3;
    send_valid = 1'b1;
    tick();
    send_valid = 1'b0;
    tick();
    chk("t6_req_rise", 32'(req), 32'd1);
`ifdef CDC_TX_TIMEOUT_EN
    for (int i = 2; i <= 17; i++) begin
      tick();
      if (i < 17) begin
        chk("t6_req_hold", 32'(req), 32'd1);
        chk("t6_no_error_yet", 32'(error), 32'd0);
      end else begin
        chk("t6_req_drop", 32'(req), 32'd0);
        chk("t6_error_pulse", 32'(error), 32'd1);
        chk("t6_no_done", 32'(done), 32'd0);
      end
    end
    tick();
    chk("t6_error_one_cycle", 32'(error), 32'd0);
    chk("t6_ready_after_abort", 32'(send_ready), 32'd1);
`else
    repeat (120) tick();
    chk("t6_req_stuck", 32'(req), 32'd1);
    chk("t6_error_never", 32'(err_seen), 32'd0);
`endif
    chk("t6_done_count", 32'(done_cnt - base_cnt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
